// File: rtl/pla_sweep_ctrl_if.sv
// Bus between the PLA sweep sequencer and the equivalence-check harness.
// master = harness side (start/abort, DUT and reference outputs); slave = sequencer.
interface pla_sweep_ctrl_if #(
  parameter int N_IN = 7
);
  logic            start;
  logic            abort;
  logic [N_IN-1:0] vec;
  logic            dut_y;
  logic            ref_y;
  logic            busy;
  logic            done;
  logic [N_IN:0]   onset_cnt;
  logic [N_IN:0]   mism_cnt;
  logic [N_IN-1:0] first_bad;
  logic            first_bad_vld;
  logic [15:0]     sig;

  modport master (
    output start, abort, dut_y, ref_y,
    input  vec, busy, done, onset_cnt, mism_cnt, first_bad, first_bad_vld, sig
  );

  modport slave (
    input  start, abort, dut_y, ref_y,
    output vec, busy, done, onset_cnt, mism_cnt, first_bad, first_bad_vld, sig
  );
endinterface

// File: rtl/pla_sweep_ctrl.sv
// Exhaustive-sweep sequencer: walks all 2^N_IN vectors through DUT and reference, counting onset/mismatches.
// Optional output MISR enabled by defining PLA_SWEEP_SIGNATURE_EN; otherwise sig is tied to zero.
module pla_sweep_ctrl #(
  parameter int N_IN       = 7,
  parameter int SETTLE_CYC = 0
) (
  input  logic             clk,
  input  logic             rst,
  pla_sweep_ctrl_if.slave  bus
);

  localparam int HW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(SETTLE_CYC);
  localparam logic [N_IN-1:0] VEC_LAST  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r, state_nx;
  logic [N_IN-1:0] vec_r, vec_nx;
  logic [HW-1:0]   hold_r, hold_nx;
  logic [N_IN:0]   onset_r, onset_nx;
  logic [N_IN:0]   mism_r, mism_nx;
  logic [N_IN-1:0] first_bad_r, first_bad_nx;
  logic            fbv_r, fbv_nx;
  logic            busy_r, busy_nx;
  logic            done_r, done_nx;
  logic            sample_s;

`ifdef PLA_SWEEP_SIGNATURE_EN
  logic [15:0] sig_r, sig_nx;

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic d);
    return {s[14:0], 1'b0} ^ ((s[15] ^ d) ? 16'h1021 : 16'h0000);
  endfunction
`endif

  assign sample_s = (state_r == RUN) && (hold_r == HOLD_LAST);

  // Next-state and next-datapath decode; abort pre-empts any sample update.
  always_comb begin
    state_nx     = state_r;
    vec_nx       = vec_r;
    hold_nx      = hold_r;
    onset_nx     = onset_r;
    mism_nx      = mism_r;
    first_bad_nx = first_bad_r;
    fbv_nx       = fbv_r;
    busy_nx      = busy_r;
    done_nx      = done_r;
`ifdef PLA_SWEEP_SIGNATURE_EN
    sig_nx       = sig_r;
`endif
    if (bus.abort) begin
      state_nx = IDLE;
      busy_nx  = 1'b0;
      done_nx  = 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (bus.start) begin
            state_nx     = RUN;
            vec_nx       = '0;
            hold_nx      = '0;
            onset_nx     = '0;
            mism_nx      = '0;
            first_bad_nx = '0;
            fbv_nx       = 1'b0;
            busy_nx      = 1'b1;
            done_nx      = 1'b0;
`ifdef PLA_SWEEP_SIGNATURE_EN
            sig_nx       = 16'hFFFF;
`endif
          end else begin
            state_nx = state_r;
          end
        end
        RUN: begin
          if (sample_s) begin
            onset_nx = onset_r + (N_IN + 1)'(bus.dut_y);
            if (bus.dut_y != bus.ref_y) begin
              mism_nx = mism_r + (N_IN + 1)'(1);
              if (!fbv_r) begin
                first_bad_nx = vec_r;
                fbv_nx       = 1'b1;
              end else begin
                fbv_nx = fbv_r;
              end
            end else begin
              mism_nx = mism_r;
            end
`ifdef PLA_SWEEP_SIGNATURE_EN
            sig_nx = misr_step(sig_r, bus.dut_y);
`endif
            // Last vector wraps the counter back to zero as DONE is entered.
            vec_nx  = vec_r + N_IN'(1);
            hold_nx = '0;
            if (vec_r == VEC_LAST) begin
              state_nx = DONE;
              busy_nx  = 1'b0;
              done_nx  = 1'b1;
            end else begin
              state_nx = RUN;
            end
          end else begin
            hold_nx = hold_r + HW'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
          done_nx  = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      vec_r       <= '0;
      hold_r      <= '0;
      onset_r     <= '0;
      mism_r      <= '0;
      first_bad_r <= '0;
      fbv_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef PLA_SWEEP_SIGNATURE_EN
      sig_r       <= 16'h0000;
`endif
    end else begin
      state_r     <= state_nx;
      vec_r       <= vec_nx;
      hold_r      <= hold_nx;
      onset_r     <= onset_nx;
      mism_r      <= mism_nx;
      first_bad_r <= first_bad_nx;
      fbv_r       <= fbv_nx;
      busy_r      <= busy_nx;
      done_r      <= done_nx;
`ifdef PLA_SWEEP_SIGNATURE_EN
      sig_r       <= sig_nx;
`endif
    end
  end

  assign bus.vec           = vec_r;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.onset_cnt     = onset_r;
  assign bus.mism_cnt      = mism_r;
  assign bus.first_bad     = first_bad_r;
  assign bus.first_bad_vld = fbv_r;
`ifdef PLA_SWEEP_SIGNATURE_EN
  assign bus.sig           = sig_r;
`else
  assign bus.sig           = 16'h0000;
`endif

endmodule

// File: tb/tb_pla_sweep_ctrl.sv
// Scoreboard bench for pla_sweep_ctrl: two instances (SETTLE_CYC 0 and 2), results checked when done rises.
module tb_pla_sweep_ctrl;

  typedef struct {
    int          onset;
    int          mism;
    int          fb;
    int          fbv;
    logic [15:0] sig;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   mode1 = 0;
  int   ph = 0;
  logic glitch = 1'b0;
  exp_t q1[$];
  exp_t q2[$];

  pla_sweep_ctrl_if #(.N_IN(7)) b1();
  pla_sweep_ctrl_if #(.N_IN(7)) b2();

  pla_sweep_ctrl #(.N_IN(7), .SETTLE_CYC(0)) u1 (.clk(clk), .rst(rst), .bus(b1));
  pla_sweep_ctrl #(.N_IN(7), .SETTLE_CYC(2)) u2 (.clk(clk), .rst(rst), .bus(b2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus functions of the current vector (mode 0: y=x0, mode 1: ref=AND, dut=0, else constant 1).
  always_comb begin
    case (mode1)
      0:       begin b1.dut_y = b1.vec[0]; b1.ref_y = b1.vec[0]; end
      1:       begin b1.dut_y = 1'b0;      b1.ref_y = &b1.vec;   end
      default: begin b1.dut_y = 1'b1;      b1.ref_y = 1'b1;      end
    endcase
  end

  // Second instance sees y=x0 with glitches on every non-sample cycle of the 3-cycle hold.
  always @(posedge clk) begin
    if (b2.start && !b2.busy) ph <= 0;
    else ph <= (ph == 2) ? 0 : ph + 1;
  end
  always @(negedge clk) glitch <= 1'($urandom_range(0, 1));
  assign b2.dut_y = b2.vec[0] ^ (glitch & (ph != 2));
  assign b2.ref_y = b2.vec[0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] misr_model(input int mode);
    logic [15:0] s;
    logic        d;
    s = 16'hFFFF;
    for (int v = 0; v < 128; v++) begin
      d = (mode == 0) ? v[0] : ((mode == 1) ? 1'b0 : 1'b1);
      s = {s[14:0], 1'b0} ^ ((s[15] ^ d) ? 16'h1021 : 16'h0000);
    end
    return s;
  endfunction

  function automatic exp_t make_exp(input int mode, input int settle, input int now);
    exp_t e;
    e.onset = (mode == 0) ? 64 : ((mode == 1) ? 0 : 128);
    e.mism  = (mode == 1) ? 1 : 0;
    e.fb    = (mode == 1) ? 127 : 0;
    e.fbv   = (mode == 1) ? 1 : 0;
`ifdef PLA_SWEEP_SIGNATURE_EN
    e.sig   = misr_model(mode);
`else
    e.sig   = 16'h0000;
`endif
    e.done_cyc = now + 1 + 128 * (settle + 1);
    return e;
  endfunction

  // Monitor: on each rising done, pop the oldest expectation and compare all results.
  logic done1_q = 1'b0;
  logic done2_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (b1.done && !done1_q) begin
      if (q1.size() == 0) chk("u1_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("u1_done_cycle", cyc, e.done_cyc);
        chk("u1_busy_at_done", {31'd0, b1.busy}, 32'd0);
        chk("u1_onset", {24'd0, b1.onset_cnt}, e.onset);
        chk("u1_mism", {24'd0, b1.mism_cnt}, e.mism);
        chk("u1_first_bad", {25'd0, b1.first_bad}, e.fb);
        chk("u1_first_bad_vld", {31'd0, b1.first_bad_vld}, e.fbv);
        chk("u1_sig", {16'd0, b1.sig}, {16'd0, e.sig});
      end
    end
    if (b2.done && !done2_q) begin
      if (q2.size() == 0) chk("u2_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q2.pop_front();
        chk("u2_done_cycle", cyc, e.done_cyc);
        chk("u2_onset", {24'd0, b2.onset_cnt}, e.onset);
        chk("u2_mism", {24'd0, b2.mism_cnt}, e.mism);
        chk("u2_first_bad_vld", {31'd0, b2.first_bad_vld}, e.fbv);
        chk("u2_sig", {16'd0, b2.sig}, {16'd0, e.sig});
      end
    end
    done1_q <= b1.done;
    done2_q <= b2.done;
  end

  task automatic start1(input int mode, input bit push);
    mode1 = mode;
    b1.start = 1'b1;
    if (push) q1.push_back(make_exp(mode, 0, cyc));
    @(negedge clk);
    b1.start = 1'b0;
  endtask

  task automatic wait_done1(input int budget);
    int n;
    n = 0;
    while (!b1.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!b1.done) chk("u1_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_vec"}, {25'd0, b1.vec}, 32'd0);
    chk({tag, "_busy"}, {31'd0, b1.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, b1.done}, 32'd0);
    chk({tag, "_onset"}, {24'd0, b1.onset_cnt}, 32'd0);
    chk({tag, "_mism"}, {24'd0, b1.mism_cnt}, 32'd0);
    chk({tag, "_first_bad"}, {25'd0, b1.first_bad}, 32'd0);
    chk({tag, "_fbv"}, {31'd0, b1.first_bad_vld}, 32'd0);
    chk({tag, "_sig"}, {16'd0, b1.sig}, 32'd0);
  endtask

  initial begin
    int n;
    int k2;
    int hold_err;
    b1.start = 1'b0; b1.abort = 1'b0;
    b2.start = 1'b0; b2.abort = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");

    // Full sweep y=x0, then back-to-back constant-1 sweep started in the first DONE cycle.
    start1(0, 1'b1);
    wait_done1(200);
    start1(2, 1'b1);
    wait_done1(200);

    start1(1, 1'b1);
    wait_done1(200);

    // Start pulse in RUN must neither restart nor disturb the counts.
    start1(0, 1'b1);
    repeat (10) @(negedge clk);
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    wait_done1(200);

    // Abort at vec=40 with dut_y=1.
    start1(2, 1'b0);
    n = 0;
    while (b1.vec != 7'd40 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_vec40", {25'd0, b1.vec}, 32'd40);
    b1.abort = 1'b1;
    @(negedge clk);
    b1.abort = 1'b0;
    chk("abort_busy", {31'd0, b1.busy}, 32'd0);
    chk("abort_done", {31'd0, b1.done}, 32'd0);
    chk("abort_onset_partial", {31'd0, (b1.onset_cnt == 8'd40) || (b1.onset_cnt == 8'd41)}, 32'd1);
    repeat (2) @(negedge clk);
    chk("abort_stays_idle", {31'd0, b1.busy}, 32'd0);

    // Start and abort together: nothing starts and partial counts survive.
    b1.start = 1'b1;
    b1.abort = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    b1.abort = 1'b0;
    chk("start_abort_busy", {31'd0, b1.busy}, 32'd0);
    chk("start_abort_done", {31'd0, b1.done}, 32'd0);
    chk("start_abort_onset_kept", {31'd0, (b1.onset_cnt == 8'd40) || (b1.onset_cnt == 8'd41)}, 32'd1);

    // Fresh start after abort clears the counts.
    start1(0, 1'b1);
    chk("restart_onset_clear", {24'd0, b1.onset_cnt}, 32'd0);
    chk("restart_busy", {31'd0, b1.busy}, 32'd1);
    chk("restart_vec0", {25'd0, b1.vec}, 32'd0);
    wait_done1(200);

    // SETTLE_CYC=2 instance: each vector held 3 cycles, glitches ignored.
    b2.start = 1'b1;
    q2.push_back(make_exp(0, 2, cyc));
    k2 = cyc + 1;
    @(negedge clk);
    b2.start = 1'b0;
    hold_err = 0;
    n = 0;
    while (!b2.done && n < 500) begin
      if (b2.busy && (int'(b2.vec) != (cyc - k2) / 3)) hold_err++;
      @(negedge clk);
      n++;
    end
    chk("u2_done_reached", {31'd0, b2.done}, 32'd1);
    chk("u2_hold_3_cycles", hold_err, 32'd0);

    // Reset mid-run clears every output on the next edge.
    start1(2, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("mid_rst");

    repeat (2) @(negedge clk);
    chk("u1_queue_drained", q1.size(), 32'd0);
    chk("u2_queue_drained", q2.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
